// File: rtl/conv_window_controller_if.sv
// rtl/conv_window_controller_if.sv - control/ROM/RAM signal bundle of the convolution window controller
// master = controller side, slave = environment side (ROMs, MAC datapath, output RAM).
interface conv_window_controller_if #(
  parameter int ADDR_W = 20,
  parameter int K      = 3
);
  logic              start;
  logic              reload_w;
  logic [ADDR_W-1:0] ROM_IF_A;
  logic [ADDR_W-1:0] ROM_W_A;
  logic              ROM_IF_OE;
  logic              ROM_W_OE;
  logic [ADDR_W-1:0] RAM_A;
  logic              RAM_WE;
  logic              RAM_OE;
  logic [K-1:0]      sel_if;
  logic [K-1:0]      sel_w;
  logic              clear;
  logic              shift;
  logic              busy;
  logic              done;

  modport master (
    input  start, reload_w,
    output ROM_IF_A, ROM_W_A, ROM_IF_OE, ROM_W_OE, RAM_A, RAM_WE, RAM_OE,
           sel_if, sel_w, clear, shift, busy, done
  );

  modport slave (
    output start, reload_w,
    input  ROM_IF_A, ROM_W_A, ROM_IF_OE, ROM_W_OE, RAM_A, RAM_WE, RAM_OE,
           sel_if, sel_w, clear, shift, busy, done
  );
endinterface

// File: rtl/conv_window_controller.sv
// rtl/conv_window_controller.sv - KxK sliding-window convolution sequencer
// Walks output pixels row-major: full window fetch at row start, single column fetch per step.
module conv_window_controller #(
  parameter int IMG_W  = 258,
  parameter int IMG_H  = 258,
  parameter int K      = 3,
  parameter int ADDR_W = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  conv_window_controller_if.master  bus
);
  localparam int KK    = K * K;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int CW    = $clog2(KK + 1);
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_READ_FULL, S_READ_COL, S_WRITE, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  c;
  logic [XW-1:0]  ocol;
  logic [YW-1:0]  orow;
  logic           w_valid;

  logic           last_col, last_row;
  logic [CW-1:0]  c_full, c_col, kr, kc, sel_row, c_m1;
  logic [K-1:0]   one_k;
  logic [ADDR_W-1:0] full_a, col_a, ram_a;

  assign last_col = (ocol == XW'(OUT_W - 1));
  assign last_row = (orow == YW'(OUT_H - 1));

  // Addresses freeze on the final (latency) cycle by clamping the counter.
  assign c_full  = (c < CW'(KK)) ? c : CW'(KK - 1);
  assign c_col   = (c < CW'(K))  ? c : CW'(K - 1);
  assign kr      = c_full / CW'(K);
  assign kc      = c_full % CW'(K);
  assign c_m1    = c - CW'(1);
  assign sel_row = c_m1 / CW'(K);
  assign one_k   = {{(K-1){1'b0}}, 1'b1};

  assign full_a = (ADDR_W'(orow) + ADDR_W'(kr)) * ADDR_W'(IMG_W) + ADDR_W'(ocol) + ADDR_W'(kc);
  assign col_a  = (ADDR_W'(orow) + ADDR_W'(c_col)) * ADDR_W'(IMG_W) + ADDR_W'(ocol) + ADDR_W'(K - 1);
  assign ram_a  = ADDR_W'(orow) * ADDR_W'(OUT_W) + ADDR_W'(ocol);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      c       <= '0;
      ocol    <= '0;
      orow    <= '0;
      w_valid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          c    <= '0;
          ocol <= '0;
          orow <= '0;
        end
        S_LOAD_W: begin
          c       <= c + CW'(1);
          w_valid <= 1'b1;
        end
        S_READ_FULL, S_READ_COL: c <= c + CW'(1);
        S_WRITE: begin
          c <= '0;
          if (last_col) begin
            ocol <= '0;
            orow <= orow + YW'(1);
          end else begin
            ocol <= ocol + XW'(1);
          end
        end
        default: c <= '0;
      endcase
    end
  end

  always_comb begin
    state_nx      = state;
    bus.ROM_IF_A  = '0;
    bus.ROM_W_A   = '0;
    bus.ROM_IF_OE = 1'b0;
    bus.ROM_W_OE  = 1'b0;
    bus.RAM_A     = '0;
    bus.RAM_WE    = 1'b0;
    bus.RAM_OE    = 1'b0;
    bus.sel_if    = '0;
    bus.sel_w     = '0;
    bus.clear     = 1'b0;
    bus.shift     = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start)
          state_nx = (bus.reload_w || !w_valid) ? S_LOAD_W : S_READ_FULL;
      end
      S_LOAD_W, S_READ_FULL: begin
        bus.busy      = 1'b1;
        bus.ROM_IF_A  = full_a;
        bus.ROM_IF_OE = (c < CW'(KK));
        bus.clear     = (c == '0);
        bus.sel_if    = (c != '0) ? (one_k << sel_row) : '0;
        if (state == S_LOAD_W) begin
          bus.ROM_W_A  = ADDR_W'(c_full);
          bus.ROM_W_OE = (c < CW'(KK));
          bus.sel_w    = bus.sel_if;
        end
        if (c == CW'(KK))
          state_nx = S_WRITE;
      end
      S_READ_COL: begin
        bus.busy      = 1'b1;
        bus.ROM_IF_A  = col_a;
        bus.ROM_IF_OE = (c < CW'(K));
        bus.shift     = (c == '0);
        bus.sel_if    = (c != '0) ? (one_k << c_m1) : '0;
        if (c == CW'(K))
          state_nx = S_WRITE;
      end
      S_WRITE: begin
        bus.busy   = 1'b1;
        bus.RAM_WE = 1'b1;
        bus.RAM_A  = ram_a;
        if (last_col && last_row)
          state_nx = S_DONE;
        else if (last_col)
          state_nx = S_READ_FULL;
        else
          state_nx = S_READ_COL;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_window_controller.sv
// tb/tb_conv_window_controller.sv - directed bench for conv_window_controller (6x5 image, 3x3 kernel)
module tb_conv_window_controller;
  localparam int IMG_W = 6;
  localparam int IMG_H = 5;
  localparam int K     = 3;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_controller_if #(.ADDR_W(AW), .K(K)) bus ();

  conv_window_controller #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.ROM_IF_A, bus.ROM_W_A, bus.ROM_IF_OE, bus.ROM_W_OE, bus.RAM_A, bus.RAM_WE,
            bus.RAM_OE, bus.sel_if, bus.sel_w, bus.clear, bus.shift, bus.busy, bus.done};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Entered on a WRITE cycle; checks the next single-column fetch and its WRITE.
  task automatic col_window(input int a0, input int a1, input int a2, input int ram);
    int a[4];
    int s[4];
    a = '{a0, a1, a2, a2};
    s = '{0, 1, 2, 4};
    for (int i = 0; i < 4; i++) begin
      step();
      check("col_if_a",  bus.ROM_IF_A, a[i]);
      check("col_if_oe", bus.ROM_IF_OE, (i < 3));
      check("col_w_oe",  bus.ROM_W_OE, 0);
      check("col_sel_if", bus.sel_if, s[i]);
      check("col_sel_w", bus.sel_w, 0);
      check("col_shift", bus.shift, (i == 0));
      check("col_clear", bus.clear, 0);
    end
    step();
    check("col_ram_we", bus.RAM_WE, 1);
    check("col_ram_a",  bus.RAM_A, ram);
  endtask

  initial begin
    int if_tab[10];
    int sel_tab[10];
    int cyc;
    int last_a;
    int nwr;
    bit seen;
    bit prev_we;
    bit w_oe_seen;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.reload_w = 1'b0;
    repeat (2) step();
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    step();
    check("idle_outs", outs(), 0);

    // Frame 1: weight reload, first full window
    bus.start = 1'b1;
    bus.reload_w = 1'b1;
    step();
    bus.start = 1'b0;
    bus.reload_w = 1'b0;
    if_tab  = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 14};
    sel_tab = '{0, 1, 1, 1, 2, 2, 2, 4, 4, 4};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      check("load_if_a", bus.ROM_IF_A, if_tab[i]);
      check("load_w_a",  bus.ROM_W_A, (i < 9) ? i : 8);
      check("load_oes",  {bus.ROM_IF_OE, bus.ROM_W_OE}, (i < 9) ? 2'b11 : 2'b00);
      check("load_sel_if", bus.sel_if, sel_tab[i]);
      check("load_sel_w",  bus.sel_w, sel_tab[i]);
      check("load_clear",  bus.clear, (i == 0));
      check("load_busy",   bus.busy, 1);
    end
    step();
    check("write0_we", bus.RAM_WE, 1);
    check("write0_a",  bus.RAM_A, 0);

    col_window(3, 9, 15, 1);
    col_window(4, 10, 16, 2);
    col_window(5, 11, 17, 3);

    // Row 1 starts with a full refetch, weights untouched
    if_tab = '{6, 7, 8, 12, 13, 14, 18, 19, 20, 20};
    for (int i = 0; i < 10; i++) begin
      step();
      check("full_if_a",  bus.ROM_IF_A, if_tab[i]);
      check("full_if_oe", bus.ROM_IF_OE, (i < 9));
      check("full_w_oe",  bus.ROM_W_OE, 0);
      check("full_w_a",   bus.ROM_W_A, 0);
      check("full_sel_if", bus.sel_if, sel_tab[i]);
      check("full_sel_w", bus.sel_w, 0);
      check("full_clear", bus.clear, (i == 0));
    end
    step();
    check("write4_we", bus.RAM_WE, 1);
    check("write4_a",  bus.RAM_A, 4);

    cyc = 36;
    last_a = 4;
    nwr = 5;
    seen = 0;
    prev_we = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      prev_we = bus.RAM_WE;
      step();
      cyc++;
      if (bus.RAM_WE) begin
        last_a = int'(bus.RAM_A);
        nwr++;
      end
      if (bus.done) seen = 1;
    end
    check("f1_done_seen", seen, 1);
    check("f1_done_cycle", cyc, 78);
    check("f1_last_ram_a", last_a, 11);
    check("f1_writes", nwr, 12);
    check("f1_write_before_done", prev_we, 1);
    step();
    check("f1_idle_busy", bus.busy, 0);
    check("f1_done_pulse", bus.done, 0);

    // Frame 2: weights cached, start pulsed mid-frame and on DONE exit
    bus.start = 1'b1;
    bus.reload_w = 1'b0;
    step();
    bus.start = 1'b0;
    check("f2_first_w_oe", bus.ROM_W_OE, 0);
    check("f2_first_clear", bus.clear, 1);
    check("f2_first_if_a", bus.ROM_IF_A, 0);
    check("f2_first_busy", bus.busy, 1);
    cyc = 0;
    seen = 0;
    w_oe_seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.ROM_W_OE) w_oe_seen = 1;
      bus.start    = (cyc == 20);
      bus.reload_w = (cyc == 20);
      step();
      cyc++;
      if (bus.done) seen = 1;
    end
    check("f2_done_seen", seen, 1);
    check("f2_done_cycle", cyc, 78);
    check("f2_no_w_oe", w_oe_seen, 0);
    bus.start = 1'b1;
    bus.reload_w = 1'b1;
    step();
    bus.start = 1'b0;
    bus.reload_w = 1'b0;
    check("f2_start_on_done_busy", bus.busy, 0);
    step();
    check("f2_still_idle", outs(), 0);

    // Frame 3: abort in READ_COL clears cached weights
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (11) step();
    check("f3_col_shift", bus.shift, 1);
    step();
    check("f3_col_if_oe", bus.ROM_IF_OE, 1);
    rst = 1'b1;
    step();
    check("f3_abort_outs", outs(), 0);
    rst = 1'b0;
    bus.start = 1'b1;
    bus.reload_w = 1'b0;
    step();
    bus.start = 1'b0;
    check("f3_reload_w_oe", bus.ROM_W_OE, 1);
    check("f3_reload_clear", bus.clear, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/conv_window_controller.md
Name: conv_window_controller

Overview:
- Parametrised successor to the fixed 3x3 / 258x258 mini-system convolution controller.
- Generalised in image size, kernel size K and address width.
- Adds a start/busy/done handshake and optional weight-reload skip.
- Drives a K-row one-hot select pipeline aligned to 1-cycle ROM latency, plus window clear/shift strobes.
- Sits between the IF/W ROMs, the MAC datapath and the output RAM.

Parameters:
IMG_W, 258, input feature-map width in pixels
IMG_H, 258, input feature-map height in pixels
K, 3, square kernel size (K >= 2); OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1
ADDR_W, 20, ROM/RAM address width; IMG_W*IMG_H <= 2^ADDR_W required

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin one full frame; sampled in IDLE only
reload_w  input  1  sampled with start; 1 = fetch K*K weights this frame
ROM_IF_A  output  ADDR_W  input-feature ROM address
ROM_W_A  output  ADDR_W  weight ROM address
ROM_IF_OE  output  1  feature ROM read enable
ROM_W_OE  output  1  weight ROM read enable
RAM_A  output  ADDR_W  output RAM address
RAM_WE  output  1  output RAM write enable
RAM_OE  output  1  tied 0 (bus compatibility)
sel_if  output  K  one-hot kernel row of feature data returning this cycle; 0 = none
sel_w  output  K  one-hot kernel row of weight data returning this cycle; 0 = none
clear  output  1  1-cycle pulse: datapath flushes whole window
shift  output  1  1-cycle pulse: datapath shifts window left by one column
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse at frame end

Behaviour:
- Reset:
  - All outputs 0; state IDLE; orow = ocol = 0; counter c = 0.
  - Internal w_valid = 0.
  - Reset mid-operation aborts the frame; outputs are 0 on the next cycle.
- IDLE:
  - All outputs 0.
  - start = 1 -> LOAD_W if (reload_w | !w_valid), else READ_FULL.
  - orow, ocol cleared.
- LOAD_W: K*K+1 cycles, c = 0..K*K.
  - For c < K*K: ROM_IF_OE = ROM_W_OE = 1, ROM_W_A = c, ROM_IF_A = (orow + c/K)*IMG_W + ocol + c%K.
  - At c = K*K: both OEs 0, addresses hold their last value.
  - sel_if = sel_w = onehot((c-1)/K) for c >= 1; 0 at c = 0 (1-cycle ROM latency).
  - clear = 1 at c = 0.
  - Sets w_valid = 1. Next state WRITE.
- READ_FULL: identical to LOAD_W except ROM_W_OE = 0, ROM_W_A = 0, sel_w = 0. Next state WRITE.
- READ_COL: K+1 cycles, c = 0..K.
  - For c < K: ROM_IF_OE = 1, ROM_IF_A = (orow + c)*IMG_W + ocol + K-1.
  - sel_if = onehot(c-1) for c >= 1.
  - shift = 1 at c = 0.
  - Next state WRITE.
- WRITE: 1 cycle.
  - RAM_WE = 1, RAM_A = orow*OUT_W + ocol, counter reset.
  - Last pixel (ocol = OUT_W-1 and orow = OUT_H-1) -> DONE.
  - End of row (ocol = OUT_W-1) -> ocol = 0, orow++, READ_FULL.
  - Otherwise -> ocol++, READ_COL.
- DONE: done = 1 for one cycle -> IDLE. w_valid is retained.
- Handshake:
  - start while busy is ignored.
  - start on the same cycle DONE exits is ignored; it must be asserted in IDLE.
- Arithmetic:
  - All address math is unsigned, truncated to ADDR_W.
  - Counter width clog2(K*K+1).
  - ocol/orow widths sized for OUT_W/OUT_H.
- Timing:
  - Row cycles = (K*K+2) + (OUT_W-1)*(K+2).
  - Frame cycles = OUT_H * row cycles + 1 (DONE).
  - Defaults: 1286 per row, 329217 per frame.

Test Plan (IMG_W=6, IMG_H=5, K=3 -> OUT_W=4, OUT_H=3):
1. rst, then start=1, reload_w=1 -> LOAD_W next cycle.
   - ROM_W_A 0..8; ROM_IF_A 0,1,2,6,7,8,12,13,14.
   - sel_w/sel_if 000, 001x3, 010x3, 100x3.
   - clear at first cycle; then WRITE with RAM_A=0.
2. Following column -> shift=1 at first cycle; ROM_IF_A 3,9,15; sel_if 000,001,010,100; WRITE RAM_A=1. Next column: ROM_IF_A 4,10,16.
3. After WRITE RAM_A=3 -> READ_FULL.
   - ROM_IF_A 6,7,8,12,13,14,18,19,20; ROM_W_OE=0, sel_w=0, clear=1.
   - WRITE RAM_A=4.
4. Full frame -> last WRITE RAM_A=11.
   - done=1 exactly one cycle after it; busy=0 the cycle after.
   - start-to-done = 78 cycles of LOAD_W/READ/WRITE + DONE.
5. Second start with reload_w=0 -> READ_FULL directly; ROM_W_OE never asserted during the frame.
6. Two reset/abort checks:
   - start pulsed while busy -> no effect.
   - rst during READ_COL -> all outputs 0 next cycle; a later start with reload_w=0 still enters LOAD_W (w_valid cleared).
